// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs little-endian bytes into 32-bit
// words, writes them at sequential addresses from BASE_ADDR and holds the core meanwhile.
module imem_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [ADDR_W:0] i_word_count,
    input  logic            i_byte_valid,
    input  logic [7:0]      i_byte_data,
    output logic            o_byte_ready,
    output logic            o_imem_we,
    output logic [31:0]     o_imem_waddr,
    output logic [31:0]     o_imem_wdata,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_cpu_hold
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W:0] CAP   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] W_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          r_state;
    logic [ADDR_W:0] r_count;
    logic [ADDR_W:0] r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [23:0]     r_word;
    logic            r_byte_ready;
    logic            r_we;
    logic [31:0]     r_waddr;
    logic [31:0]     r_wdata;
    logic            r_busy;
    logic            r_done;

    logic [ADDR_W:0] w_count;
    logic [ADDR_W:0] w_next_idx;
    logic            w_accept;
    logic [31:0]     w_word_off;

    assign w_count    = (i_word_count > CAP) ? CAP : i_word_count;
    assign w_next_idx = r_word_idx + W_ONE;
    assign w_accept   = i_byte_valid && r_byte_ready;
    assign w_word_off = {{(31 - ADDR_W - 2){1'b0}}, r_word_idx, 2'b00};

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_count    <= w_count;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_busy     <= 1'b1;
                        if (w_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_COLLECT;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= i_byte_data;
                            2'd1: r_word[15:8]  <= i_byte_data;
                            2'd2: r_word[23:16] <= i_byte_data;
                            default: begin
                                // Lane 3 goes straight into the write word, saving a cycle.
                                r_state      <= S_WRITE;
                                r_byte_ready <= 1'b0;
                                r_we         <= 1'b1;
                                r_waddr      <= BASE_ADDR + w_word_off;
                                r_wdata      <= {i_byte_data, r_word};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_word_idx <= w_next_idx;
                    if (w_next_idx == r_count) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_imem_we    = r_we;
    assign o_imem_waddr = r_waddr;
    assign o_imem_wdata = r_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_cpu_hold   = r_busy;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected imem writes into a
// queue, an independent negedge monitor pops and compares every write strobe.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [ADDR_W:0] word_count = '0;
    logic            byte_valid = 1'b0;
    logic [7:0]      byte_data = '0;
    logic            o_byte_ready, o_imem_we, o_busy, o_done, o_cpu_hold;
    logic [31:0]     o_imem_waddr, o_imem_wdata;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_word_count(word_count),
        .i_byte_valid(byte_valid), .i_byte_data(byte_data),
        .o_byte_ready(o_byte_ready), .o_imem_we(o_imem_we),
        .o_imem_waddr(o_imem_waddr), .o_imem_wdata(o_imem_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_cpu_hold(o_cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    logic        prev_done = 1'b0;
    logic [31:0] last_waddr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (o_imem_we === 1'b1) begin
            we_cnt++;
            last_waddr = o_imem_waddr;
            if (exp_q.size() == 0) fail_now("unexpected_write");
            else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("waddr", o_imem_waddr, e.a);
                chk("wdata", o_imem_wdata, e.d);
            end
        end
        if (prev_done) begin
            chk("busy_after_done", {31'b0, o_busy}, 32'd0);
            chk("hold_after_done", {31'b0, o_cpu_hold}, 32'd0);
        end
        if (o_done === 1'b1) begin
            done_cnt++;
            chk("hold_with_done", {31'b0, o_cpu_hold}, 32'd1);
        end
        prev_done = (o_done === 1'b1);
    end

    task automatic start_load(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        word_count = n[ADDR_W:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int t;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_valid = 1'b1;
        byte_data = b;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = (o_byte_ready === 1'b1);
            @(posedge clk); #1;
            t++;
        end
        byte_valid = 1'b0;
        if (!acc) fail_now("byte_accept_timeout");
    endtask

    task automatic wait_done(input int max);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < max && !seen; t++) begin
            @(negedge clk);
            if (o_done === 1'b1) seen = 1'b1;
        end
        if (!seen) fail_now("done_timeout");
    endtask

    // Two-word load of 78 56 34 12 EF BE AD DE, random 1..3 idle gap if gapmax>0.
    task automatic two_word_load(input int gapmax);
        logic [7:0] s[8];
        int we0, d0;
        s = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        we0 = we_cnt;
        d0 = done_cnt;
        exp_q.push_back('{32'h0000_0000, 32'h1234_5678});
        exp_q.push_back('{32'h0000_0004, 32'hDEAD_BEEF});
        start_load(2);
        for (int i = 0; i < 8; i++) begin
            send_byte(s[i], (gapmax == 0) ? 0 : $urandom_range(1, gapmax));
            if (gapmax == 0 && i == 3) begin
                @(negedge clk);
                chk("latency_we", {31'b0, o_imem_we}, 32'd1);
            end
        end
        wait_done(100);
        repeat (3) @(negedge clk);
        chk("two_word_we_count", we_cnt - we0, 32'd2);
        chk("two_word_done_count", done_cnt - d0, 32'd1);
        chk("two_word_queue_empty", exp_q.size(), 32'd0);
    endtask

    function automatic logic [7:0] pat(input int j);
        int v;
        v = (j * 7 + 3) & 255;
        return v[7:0];
    endfunction

    initial begin
        int we0, d0;

        // 1: reset with noisy inputs
        start = 1'b1;
        byte_valid = 1'b1;
        word_count = 11'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ready", {31'b0, o_byte_ready}, 32'd0);
            chk("rst_we", {31'b0, o_imem_we}, 32'd0);
            chk("rst_busy", {31'b0, o_busy}, 32'd0);
            chk("rst_done", {31'b0, o_done}, 32'd0);
            chk("rst_hold", {31'b0, o_cpu_hold}, 32'd0);
            chk("rst_waddr", o_imem_waddr, 32'd0);
            chk("rst_wdata", o_imem_wdata, 32'd0);
        end
        start = 1'b0;
        byte_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'b0, o_busy}, 32'd0);
        chk("idle_ready", {31'b0, o_byte_ready}, 32'd0);

        // 2: back-to-back stream, then surplus bytes must be refused
        two_word_load(0);
        byte_valid = 1'b1;
        byte_data = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            chk("no_ready_after_load", {31'b0, o_byte_ready}, 32'd0);
        end
        byte_valid = 1'b0;

        // 3: zero-word load
        we0 = we_cnt;
        d0 = done_cnt;
        start_load(0);
        @(negedge clk);
        chk("zero_done", {31'b0, o_done}, 32'd1);
        chk("zero_ready", {31'b0, o_byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("zero_no_we", we_cnt - we0, 32'd0);
        chk("zero_done_count", done_cnt - d0, 32'd1);

        // 4: same stream with idle gaps
        two_word_load(3);

        // 5: reset mid-word, then restart at base
        we0 = we_cnt;
        start_load(2);
        send_byte(8'hA0, 0);
        send_byte(8'hA1, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", {31'b0, o_busy}, 32'd0);
        chk("midrst_ready", {31'b0, o_byte_ready}, 32'd0);
        chk("midrst_no_we", we_cnt - we0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back('{32'h0000_0000, 32'h0000_0013});
        start_load(1);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done(50);
        repeat (2) @(negedge clk);
        chk("restart_we_count", we_cnt - we0, 32'd1);
        chk("restart_queue_empty", exp_q.size(), 32'd0);

        // 6: oversize count clamps to capacity (2048 is not representable in
        // ADDR_W+1 bits, so the largest encodable count is used); stray start mid-load
        we0 = we_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 1024; i++)
            exp_q.push_back('{i * 4, {pat(4*i+3), pat(4*i+2), pat(4*i+1), pat(4*i)}});
        start_load(2047);
        for (int j = 0; j < 4096; j++) begin
            if (j == 2001) start = 1'b1;
            send_byte(pat(j), 0);
            start = 1'b0;
        end
        wait_done(200);
        repeat (3) @(negedge clk);
        chk("clamp_we_count", we_cnt - we0, 32'd1024);
        chk("clamp_last_addr", last_waddr, 32'h0000_0FFC);
        chk("clamp_done_count", done_cnt - d0, 32'd1);
        chk("clamp_queue_empty", exp_q.size(), 32'd0);
        byte_valid = 1'b1;
        @(negedge clk);
        chk("clamp_no_extra_ready", {31'b0, o_byte_ready}, 32'd0);
        byte_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        fail_now("watchdog");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
